timer_ctrl: RTL

//  Sequencing controller for four cascaded BCD digit counters (MM:SS, d3..d0) in the timer/stopwatch.

---
 rtl/timer_pkg.sv | 19 +
 rtl/digit_carry_gen.sv | 23 ++
 rtl/timer_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS timer/stopwatch sequencing controller.
package timer_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_SW  = 1'b0;
  localparam logic MODE_TMR = 1'b1;

  // Wrap value of each digit, {d3,d2,d1,d0}
  localparam logic [NUM_DIGITS*4-1:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9};

endpackage

// File: rtl/digit_carry_gen.sv
// Carry/borrow enable mask for the digit chain: bit k is set when every lower
// digit sits at its wrap value (counting up) or at zero (counting down).
module digit_carry_gen
  import timer_pkg::*;
(
  input  logic [(NUM_DIGITS-1)*4-1:0] i_lower_vals,
  input  logic                        i_down,
  output logic [NUM_DIGITS-1:0]       o_en
);

  logic [NUM_DIGITS-2:0] at_edge;

  always_comb begin
    at_edge = '0;
    for (int k = 0; k < NUM_DIGITS-1; k++) begin
      at_edge[k] = i_down ? (i_lower_vals[4*k +: 4] == 4'd0)
                          : (i_lower_vals[4*k +: 4] == DIGIT_MAX[4*k +: 4]);
    end
  end

  assign o_en = {&at_edge[2:0], &at_edge[1:0], at_edge[0], 1'b1};

endmodule

// File: rtl/timer_ctrl.sv
// Start/pause/done sequencer driving per-digit up/down strobes for the MM:SS counter bank.
// Optional DONE blink of o_blank is built only when TIMER_DONE_BLINK_EN is defined.
//
//  state | meaning
//  IDLE  | stopped; digits may be set or cleared, mode is sampled on start
//  RUN   | ticks advance the digits in the latched direction
//  PAUSE | frozen; start resumes, clear returns to IDLE
//  DONE  | limit reached; only clear leaves
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int BLINK_TICKS = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_tick,
  input  logic                          i_mode,
  input  logic                          i_start_stop,
  input  logic                          i_clear,
  input  logic                          i_set_inc,
  input  logic [1:0]                    i_set_sel,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_digit_vals,
  output logic [NUM_DIGITS-1:0]         o_cnt_up,
  output logic [NUM_DIGITS-1:0]         o_cnt_dwn,
  output logic                          o_digit_reset,
  output logic [NUM_DIGITS*DIGIT_W-1:0] o_max_count,
  output logic                          o_running,
  output logic                          o_done,
  output logic                          o_blank
);

  if (DIGIT_W != 4 || BLINK_TICKS < 1) begin : g_param_check
    $error("timer_ctrl: DIGIT_W must be 4 and BLINK_TICKS must be >= 1");
  end

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [NUM_DIGITS-1:0] cnt_up_q, cnt_up_d;
  logic [NUM_DIGITS-1:0] cnt_dwn_q, cnt_dwn_d;
  logic                  digit_reset_q, digit_reset_d;
  logic                  chk_q;
  logic [NUM_DIGITS-1:0] chain_en;
  logic                  digits_zero, digits_full, dwn_landed;

  digit_carry_gen u_carry (
    .i_lower_vals (i_digit_vals[(NUM_DIGITS-1)*4-1:0]),
    .i_down       (mode_q),
    .o_en         (chain_en)
  );

  assign digits_zero = (i_digit_vals == '0);
  assign digits_full = (i_digit_vals == DIGIT_MAX);
  // Digits settle one cycle after a down strobe, so zero is judged on the following cycle
  assign dwn_landed  = chk_q && (mode_q == MODE_TMR) && digits_zero;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    cnt_up_d      = '0;
    cnt_dwn_d     = '0;
    digit_reset_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_clear) begin
          digit_reset_d = 1'b1;
        end else if (i_start_stop) begin
          if (!(i_mode == MODE_TMR && digits_zero)) begin
            state_d = RUN;
            mode_d  = i_mode;
          end
        end else if (i_set_inc) begin
          cnt_up_d = NUM_DIGITS'(1) << i_set_sel;
        end
      end
      RUN: begin
        if (dwn_landed) begin
          state_d = DONE;
        end else begin
          if (i_tick) begin
            if (mode_q == MODE_SW) begin
              if (digits_full) state_d = DONE;
              else             cnt_up_d = chain_en;
            end else begin
              if (digits_zero) state_d = DONE;
              else             cnt_dwn_d = chain_en;
            end
          end
          if (i_start_stop && state_d == RUN) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (i_clear) begin
          digit_reset_d = 1'b1;
          state_d       = IDLE;
        end else if (dwn_landed) begin
          state_d = DONE;
        end else if (i_start_stop) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (i_clear) begin
          digit_reset_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      mode_q        <= MODE_SW;
      cnt_up_q      <= '0;
      cnt_dwn_q     <= '0;
      digit_reset_q <= 1'b0;
      chk_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cnt_up_q      <= cnt_up_d;
      cnt_dwn_q     <= cnt_dwn_d;
      digit_reset_q <= digit_reset_d;
      chk_q         <= |cnt_dwn_q;
    end
  end

  assign o_cnt_up      = cnt_up_q;
  assign o_cnt_dwn     = cnt_dwn_q;
  assign o_digit_reset = digit_reset_q;
  assign o_max_count   = DIGIT_MAX;
  assign o_running     = (state_q == RUN);
  assign o_done        = (state_q == DONE);

`ifdef TIMER_DONE_BLINK_EN
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blank_q, blank_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blank_d     = blank_q;
    if (state_d != DONE) begin
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (state_q != DONE) begin
      blink_cnt_d = BLINK_W'(BLINK_TICKS-1);
      blank_d     = 1'b1;
    end else if (i_tick) begin
      if (blink_cnt_q == '0) begin
        blink_cnt_d = BLINK_W'(BLINK_TICKS-1);
        blank_d     = ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign o_blank = blank_q;
`else
  assign o_blank = 1'b0;
`endif

endmodule
